rate_tick_gen: RTL and testbench
================================

# rate_tick_gen

Programmable tick generator that produces single-cycle enable pulses at a selectable rate from the board clock. It drives the `enable` input of the downstream 8-bit T-flip-flop counter, so the counter advances visibly on the HEX displays instead of at clock speed. Rate is chosen from switches. A push-button single-step mode issues exactly one pulse per press while free-running is off.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency in Hz.
- `CNT_W`, 28: down-counter width. Must hold 4*CLK_HZ-1.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `clear` input 1: reset, synchronous, active-high. Sampled on the rising edge of `clk`.
- `run` input 1: level. 1 selects free-running ticks.
- `rate_sel` input 2: 00 every cycle; 01 1 Hz; 10 0.5 Hz; 11 0.25 Hz.
- `step` input 1: raw button level, active-high, asynchronous to `clk`.
- `tick` output 1: one-cycle enable pulse, registered.
- `running` output 1: 1 while in RUN.
- `cnt` output CNT_W: current down-counter value, for debug and verification.

## Operation
- Reload value R per `rate_sel`:
  - 00: 0.
  - 01: CLK_HZ-1.
  - 10: 2*CLK_HZ-1.
  - 11: 4*CLK_HZ-1.
  - Computed at full CNT_W width with no truncation.
- FSM states and transitions:
  - IDLE → RUN when `run`=1. On that edge, load `cnt` <= R.
  - RUN → IDLE when `run`=0. No tick is issued on that edge. `cnt` holds its value.
- In RUN:
  - If `cnt`≠0: `cnt` <= `cnt`-1.
  - If `cnt`=0: `tick` <= 1 and `cnt` <= R. Otherwise `tick` <= 0.
- `rate_sel` is registered every cycle. In RUN, any change from the registered value reloads `cnt` <= new R on the next edge. That reload suppresses the tick, except when `cnt`=0 in the same cycle (see Timing).
- Step, only with the step feature compiled in:
  - `step` passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected rising edge in IDLE sets `tick` <= 1 for one cycle.
  - Edges detected in RUN are discarded, not queued.
- `running` = (state == RUN), registered.
- Counter never wraps below 0. The reload happens at 0.

## Timing
- Reset values: state IDLE, `tick` 0, `running` 0, `cnt` 0, synchronizer flops 0, edge register 0, registered `rate_sel` 00.
- `clear` has priority over every other input in the same cycle.
- `clear` mid-RUN returns the block to IDLE on that edge. No tick is issued.
- Run latency: edge N samples `run`=1. `running`=1 after edge N. The first `tick` is high in the cycle after edge N+R+1. After that, the period is exactly R+1 cycles.
- Rate 00 in RUN: `tick` stays continuously high from edge N+1 onward.
- Step latency: `step` rises before edge S. `tick` is high for exactly the one cycle after edge S+2. Holding `step` high yields one tick only.
- `cnt`=0 and a `rate_sel` change in the same cycle: the tick is still issued and the reload uses the new R.
- `run` falling in the same cycle as `cnt`=0: no tick; IDLE wins.
- A step edge in the cycle where the FSM leaves IDLE is discarded.

## Configuration
- `RATE_TICK_STEP_EN` defined: the synchronizer, edge detector and step tick path are present.
- `RATE_TICK_STEP_EN` undefined:
  - The `step` port remains but is ignored and drives no logic.
  - `tick` comes only from RUN.
  - `tick` stays 0 in IDLE.

## Structure
- Package `rate_tick_pkg` holds:
  - The state enum typedef (IDLE, RUN).
  - The `rate_sel` encoding constants (RATE_FAST, RATE_1HZ, RATE_2S, RATE_4S).
  - A function returning R from `rate_sel`, CLK_HZ and CNT_W.
- Sub-module `step_edge_sync`: 2-flop synchronizer plus rising-edge pulse. It takes `clk`, `clear`, `in` and produces `pulse`. It is instantiated only under `RATE_TICK_STEP_EN`.

## Test plan
All scenarios use CLK_HZ=8, so R = 0, 7, 15 and 31 for `rate_sel` 00 to 11.
- Reset then `run`=1, `rate_sel`=01 for 40 cycles → ticks in the cycles after edges N+8, N+16, N+24 and N+32. Each tick is one cycle wide. `running`=1.
- `rate_sel`=11 while `cnt`=20, then `rate_sel`=01 → `cnt` becomes 7 on the next edge with no tick. The next tick follows 8 cycles later.
- `run`=1, `rate_sel`=00 → `tick` is continuously high from N+1. `run`=0 → `tick` is 0 on the next cycle and `running`=0.
- IDLE, `step` held high for 10 cycles → exactly one tick, in the cycle after edge S+2. With the macro undefined, no tick.
- `clear`=1 while in RUN with `cnt`=5 → next cycle: `cnt`=0, `tick`=0, `running`=0, even with `run` still 1. After `clear` drops, the run latency restarts from zero.
- `cnt`=0 coincident with a `rate_sel` change 01→10 → tick issued and `cnt`=15 on the next edge.

Source files
------------

// File: rtl/rate_tick_pkg.sv
// Shared types and helpers for the rate tick generator.
//   state_e      : FSM state encoding (IDLE, RUN)
//   RATE_*       : rate_sel encodings
//   rate_reload  : reload value R for a given rate_sel, clock rate and counter width
package rate_tick_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] RATE_FAST = 2'b00;
  localparam logic [1:0] RATE_1HZ  = 2'b01;
  localparam logic [1:0] RATE_2S   = 2'b10;
  localparam logic [1:0] RATE_4S   = 2'b11;

  // R is formed at 64 bits and then limited to the counter width.
  function automatic longint unsigned rate_reload(input logic [1:0]        sel,
                                                  input longint unsigned  clk_hz,
                                                  input int unsigned      cnt_w);
    longint unsigned r;
    case (sel)
      RATE_FAST: r = 64'd0;
      RATE_1HZ:  r = clk_hz - 64'd1;
      RATE_2S:   r = (64'd2 * clk_hz) - 64'd1;
      default:   r = (64'd4 * clk_hz) - 64'd1;
    endcase
    if (cnt_w < 32'd64) begin
      r = r & ((64'd1 << cnt_w) - 64'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk   : clock
//   clear : synchronous active-high reset
//   in    : asynchronous level input
//   pulse : one-cycle high when the synchronized level rises (combinational from flops)
module step_edge_sync (
  input  logic clk,
  input  logic clear,
  input  logic in,
  output logic pulse
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       prev_q;
  logic       prev_d;

  assign sync_d = {sync_q[0], in};
  assign prev_d = sync_q[1];

  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Pulse is taken straight from flop outputs so the consumer registers it once.
  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/rate_tick_gen.sv
// Programmable tick generator: single-cycle enable pulses at a switch-selected rate.
//   clk      : clock
//   clear    : synchronous active-high reset
//   run      : 1 selects free-running ticks
//   rate_sel : 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
//   step     : raw push-button level (used only with RATE_TICK_STEP_EN)
//   tick     : registered one-cycle enable pulse
//   running  : registered, 1 while in RUN
//   cnt      : current down-counter value
// Build option: define RATE_TICK_STEP_EN to include the single-step button path.
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 28
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [1:0]       rate_sel,
  input  logic             step,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] r_new;
  logic             step_pulse;

`ifdef RATE_TICK_STEP_EN
  step_edge_sync u_step_sync (
    .clk   (clk),
    .clear (clear),
    .in    (step),
    .pulse (step_pulse)
  );
`else
  logic step_unused;
  assign step_unused = step;
  assign step_pulse  = 1'b0;
`endif

  // Reload value for the rate currently on the switches.
  assign r_new = CNT_W'(rate_reload(rate_sel, 64'(CLK_HZ), CNT_W));

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      rate_q    <= RATE_FAST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      rate_q    <= rate_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    rate_d  = rate_sel;
    case (state_q)
      IDLE: begin
        if (run) begin
          // Leaving IDLE swallows any step edge seen in the same cycle.
          state_d = RUN;
          cnt_d   = r_new;
        end else if (step_pulse) begin
          tick_d = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          // Terminal count wins over a rate change; reload picks up the new rate.
          tick_d = 1'b1;
          cnt_d  = r_new;
        end else if (rate_sel != rate_q) begin
          cnt_d = r_new;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_rate_tick_gen.sv
// Self-checking bench for rate_tick_gen with CLK_HZ=8 (R = 0, 7, 15, 31).
module tb_rate_tick_gen;

  localparam int unsigned CLK_HZ = 8;
  localparam int unsigned CNT_W  = 8;
`ifdef RATE_TICK_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic             clk;
  logic             clear;
  logic             run;
  logic [1:0]       rate_sel;
  logic             step;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rate_tick_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .clear    (clear),
    .run      (run),
    .rate_sel (rate_sel),
    .step     (step),
    .tick     (tick),
    .running  (running),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks the edge at which the next tick is due.
  int k      = 0;
  bit m_run  = 1'b0;
  int m_next = 0;
  int m_held = 0;
  int m_selq = 0;
  bit m_tick = 1'b0;
  bit step_hist[$] = '{1'b0, 1'b0, 1'b0};

  function automatic int r_of(input int sel);
    if (sel == 0) return 0;
    return (CLK_HZ * (1 << (sel - 1))) - 1;
  endfunction

  function automatic int m_cnt();
    return m_run ? (m_next - 1 - k) : m_held;
  endfunction

  task automatic model_edge(input bit c, input bit r, input int sel, input bit st);
    bit pulse;
    k++;
    pulse = step_hist[1] && !step_hist[2];
    if (c) begin
      m_run = 1'b0; m_held = 0; m_tick = 1'b0; m_selq = 0;
      step_hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      if (!m_run) begin
        if (r) begin
          m_run = 1'b1; m_next = k + r_of(sel) + 1; m_tick = 1'b0;
        end else begin
          m_tick = STEP_EN && pulse;
        end
      end else if (!r) begin
        m_held = m_next - k; m_run = 1'b0; m_tick = 1'b0;
      end else if (m_next == k) begin
        m_tick = 1'b1; m_next = k + r_of(sel) + 1;
      end else begin
        m_tick = 1'b0;
        if (sel != m_selq) m_next = k + r_of(sel) + 1;
      end
      m_selq = sel;
      step_hist.push_front(st);
      void'(step_hist.pop_back());
    end
  endtask

  task automatic edge_step(input bit c, input bit r, input logic [1:0] s, input bit st);
    clear = c; run = r; rate_sel = s; step = st;
    @(posedge clk);
    model_edge(c, r, int'(s), st);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".tick"},    int'(tick),    int'(m_tick));
    check({tag, ".running"}, int'(running), int'(m_run));
    check({tag, ".cnt"},     int'(cnt),     m_cnt());
  endtask

  typedef struct {
    bit         c;
    bit         r;
    logic [1:0] s;
    bit         e_tick;
    bit         e_run;
    int         e_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    clear = 1'b1; run = 1'b0; rate_sel = 2'b00; step = 1'b0;

    // Table: {clear, run, rate_sel, tick, running, cnt} after each edge.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 7};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 6};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5};
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 31};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 7};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 6};
    vecs[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 6};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 6};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 0};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 0};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 0};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 15};
    vecs[14] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 15};

    for (int i = 0; i < 15; i++) begin
      edge_step(vecs[i].c, vecs[i].r, vecs[i].s, 1'b0);
      check($sformatf("vec%0d.tick", i),    int'(tick),    int'(vecs[i].e_tick));
      check($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].e_run));
      check($sformatf("vec%0d.cnt", i),     int'(cnt),     vecs[i].e_cnt);
    end

    // Free run at rate 01: ticks after N+8, N+16, N+24, N+32.
    edge_step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i <= 40; i++) begin
      edge_step(1'b0, 1'b1, 2'd1, 1'b0);
      check($sformatf("run1hz[%0d].tick", i), int'(tick), int'(i > 0 && (i % 8) == 0));
      check($sformatf("run1hz[%0d].cnt", i),  int'(cnt),  7 - (i % 8));
    end
    check("run1hz.running", int'(running), 1);

    // Rate change 11 -> 01 at cnt=20 reloads 7 with no tick, next tick 8 edges later.
    edge_step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i <= 11; i++) edge_step(1'b0, 1'b1, 2'd3, 1'b0);
    check("chg.cnt20", int'(cnt), 20);
    edge_step(1'b0, 1'b1, 2'd1, 1'b0);
    check("chg.reload.cnt", int'(cnt), 7);
    check("chg.reload.tick", int'(tick), 0);
    for (int i = 1; i <= 8; i++) begin
      edge_step(1'b0, 1'b1, 2'd1, 1'b0);
      check($sformatf("chg[%0d].tick", i), int'(tick), int'(i == 8));
    end

    // Rate 00: continuous ticks; dropping run stops them on the next edge.
    edge_step(1'b1, 1'b0, 2'd0, 1'b0);
    edge_step(1'b0, 1'b1, 2'd0, 1'b0);
    check("fast.n.tick", int'(tick), 0);
    for (int i = 1; i <= 5; i++) begin
      edge_step(1'b0, 1'b1, 2'd0, 1'b0);
      check($sformatf("fast[%0d].tick", i), int'(tick), 1);
    end
    edge_step(1'b0, 1'b0, 2'd0, 1'b0);
    check("fast.stop.tick", int'(tick), 0);
    check("fast.stop.running", int'(running), 0);

    // Step held high in IDLE: one tick after edge S+2 only when the feature is built.
    edge_step(1'b1, 1'b0, 2'd1, 1'b0);
    edge_step(1'b0, 1'b0, 2'd1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      edge_step(1'b0, 1'b0, 2'd1, 1'b1);
      check($sformatf("step[%0d].tick", j), int'(tick), int'(STEP_EN && j == 2));
    end
    for (int j = 0; j < 3; j++) begin
      edge_step(1'b0, 1'b0, 2'd1, 1'b0);
      check($sformatf("steprel[%0d].tick", j), int'(tick), 0);
    end

    // Step edge arriving as the FSM leaves IDLE is dropped.
    edge_step(1'b0, 1'b0, 2'd1, 1'b1);
    edge_step(1'b0, 1'b0, 2'd1, 1'b1);
    edge_step(1'b0, 1'b1, 2'd1, 1'b1);
    check("steprun.tick", int'(tick), 0);
    check("steprun.cnt", int'(cnt), 7);
    edge_step(1'b0, 1'b1, 2'd1, 1'b0);
    check("steprun2.tick", int'(tick), 0);

    // Clear mid-run with cnt=5, then latency restarts.
    edge_step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i <= 2; i++) edge_step(1'b0, 1'b1, 2'd1, 1'b0);
    check("clr.cnt5", int'(cnt), 5);
    edge_step(1'b1, 1'b1, 2'd1, 1'b0);
    check("clr.cnt", int'(cnt), 0);
    check("clr.tick", int'(tick), 0);
    check("clr.running", int'(running), 0);
    for (int i = 0; i <= 8; i++) begin
      edge_step(1'b0, 1'b1, 2'd1, 1'b0);
      check($sformatf("clrre[%0d].tick", i), int'(tick), int'(i == 8));
    end
    check("clrre.cnt", int'(cnt), 7);

    // Terminal count coincident with rate change 01 -> 10.
    edge_step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i <= 7; i++) edge_step(1'b0, 1'b1, 2'd1, 1'b0);
    check("tc.cnt0", int'(cnt), 0);
    edge_step(1'b0, 1'b1, 2'd2, 1'b0);
    check("tc.tick", int'(tick), 1);
    check("tc.cnt", int'(cnt), 15);

    // Run falling at terminal count: no tick, IDLE wins, count holds.
    edge_step(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i <= 7; i++) edge_step(1'b0, 1'b1, 2'd1, 1'b0);
    edge_step(1'b0, 1'b0, 2'd1, 1'b0);
    check("fall.tick", int'(tick), 0);
    check("fall.running", int'(running), 0);
    check("fall.cnt", int'(cnt), 0);

    // Randomized stimulus against the reference model.
    begin
      bit         r_run = 1'b1;
      bit         r_step = 1'b0;
      logic [1:0] r_sel = 2'd1;
      bit         r_clr;
      for (int i = 0; i < 3000; i++) begin
        r_clr = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 39) == 0) r_run = ~r_run;
        if ($urandom_range(0, 24) == 0) r_sel = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) r_step = ~r_step;
        edge_step(r_clr, r_run, r_sel, r_step);
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
